indicator_scan: RTL
===================

Name: indicator_scan

Overview:
- Serial driver for the QSIC indicator (blinkenlights) panel. Sits directly downstream of the top-level debug/status muxing.
- Takes four 36-bit lamp rows, snapshots them coherently once per frame, and shifts them out on a clock/data/latch chain to the panel's shift registers.
- Replaces the free-running clock-tap divider and frame counter with a proper clock-enable design running entirely in the clk20 domain.
- Outputs are true polarity. Board-level inversion is done outside this block.

Parameters:
- CLK_DIV, 100, clk20 cycles per half bit-period (100 gives a 100 kHz ip_clk from 20 MHz); legal range 1..65535
- ROW_BITS, 36, bits per lamp row; four rows are fixed, so a frame carries 4*ROW_BITS data bits

Ports:
- clk20  input  1  system clock (20 MHz)
- reset  input  1  asynchronous, active-high reset
- clear  input  1  synchronous frame restart (tied to RINIT)
- lamp_test  input  1  when sampled at LOAD, the frame shifts all ones
- row0  input  ROW_BITS  first panel row (shifted first)
- row1  input  ROW_BITS  second row
- row2  input  ROW_BITS  third row
- row3  input  ROW_BITS  fourth row (shifted last)
- ip_clk  output  1  panel shift clock; panel samples ip_out on the rising edge
- ip_out  output  1  panel serial data
- ip_latch  output  1  panel output-register load strobe
- frame_done  output  1  one-cycle pulse at the end of each complete frame

Behaviour:
- Reset (async): ip_clk=0, ip_out=0, ip_latch=0, frame_done=0; shadow register, divider, and bit counter cleared; state=LOAD.
- All outputs are registered. No combinational path from inputs to outputs.
- Divider: div_cnt counts 0..CLK_DIV-1 and produces a half-period tick at terminal count. Width is 16 bits.
- State LOAD (exactly 1 cycle):
  - shadow <= lamp_test ? all ones : {row0,row1,row2,row3}
  - ip_out <= row0[ROW_BITS-1] (or 1 if lamp_test)
  - bit_cnt <= 0, div_cnt <= 0, ip_clk=0, ip_latch=0
  - next state: SHIFT_LO
- State SHIFT_LO (CLK_DIV cycles): ip_clk=0. On tick, go to SHIFT_HI and set ip_clk=1.
- State SHIFT_HI (CLK_DIV cycles): ip_clk=1. On tick:
  - ip_clk<=0, shadow shifts left by one, ip_out <= next bit
  - if bit_cnt==4*ROW_BITS-1: go to LATCH and set ip_latch<=1
  - else: bit_cnt++ and go to SHIFT_LO
  - ip_out therefore changes only on the falling edge of ip_clk. Data is stable a full half-period either side of each rising edge.
- State LATCH (2*CLK_DIV cycles): ip_clk=0, ip_latch=1. On the second tick: ip_latch<=0, frame_done<=1 for one cycle, go to LOAD.
- Bit order: row0 bit ROW_BITS-1 first, through row3 bit 0 last.
- Timing:
  - Exactly 4*ROW_BITS ip_clk rising edges per frame.
  - Frame length = 1 + (4*ROW_BITS+1)*2*CLK_DIV cycles (29001 at defaults).
- Snapshot: row inputs and lamp_test are sampled only in LOAD. Changes mid-frame do not affect the frame in progress.
- clear: at the next clock edge the block enters LOAD state values (ip_clk=0, ip_latch=0, frame_done=0, div_cnt=0), regardless of state.
  - While clear is held, the block stays in LOAD with no ticks.
  - The first LOAD after clear deasserts performs the snapshot.
  - A truncated frame never produces ip_latch or frame_done.
- clear and a LATCH terminal tick in the same cycle: clear wins, so no frame_done.
- CLK_DIV=1: every cycle is a tick; half-periods are one cycle long.

Test Plan (CLK_DIV=2, ROW_BITS=36 unless noted; frame = 581 cycles):
- Reset held 5 cycles, then released -> all outputs 0 during reset; LOAD on the first edge; first ip_clk rise 3 cycles after release; frame_done 581 cycles after release.
- row0=36'o400000000000, rows1-3=0 -> ip_out=1 at rising edge #1 only; 0 at edges #2..#144; exactly 144 rising edges, then ip_latch high 4 cycles with ip_clk low.
- row3=36'o000000000001, lamp_test=0 -> only rising edge #144 samples ip_out=1. Repeat with lamp_test=1 -> all 144 samples are 1.
- Change row1 from 0 to all ones at rising edge #40 -> current frame shifts 0 for bits 37..72; next frame shifts 1 for bits 37..72.
- Assert clear for 1 cycle during bit 80 -> next cycle ip_clk=0, ip_latch=0; no ip_latch or frame_done for the truncated frame; the next full frame starts with a fresh snapshot and completes normally.
- Async reset asserted mid-LATCH -> ip_latch falls immediately without waiting for a clock; frame_done never pulses.

Source files
------------

// File: rtl/indicator_scan_if.sv
// Serial link to the QSIC indicator panel's shift-register chain.
// The scan driver owns the master side; the panel (or a bench model) listens
// on the slave side.
interface indicator_scan_if;
    logic ip_clk;
    logic ip_out;
    logic ip_latch;

    modport master (
        output ip_clk,
        output ip_out,
        output ip_latch
    );

    modport slave (
        input ip_clk,
        input ip_out,
        input ip_latch
    );
endinterface

// File: rtl/indicator_scan.sv
// Serial driver for the QSIC indicator panel.
// Four lamp rows are snapshotted once per frame and shifted out MSB-first
// (row0 first, row3 last) on a clock/data/latch chain. Everything runs in the
// clk20 domain. A divider produces half-bit-period ticks that pace the
// shift clock.
//
// Frame shape:
//   LOAD     : 1 cycle, snapshot the rows, present the first bit
//   SHIFT_LO : CLK_DIV cycles with ip_clk low
//   SHIFT_HI : CLK_DIV cycles with ip_clk high; on exit, drop ip_clk and
//              move to the next bit, so data only changes on falling edges
//   LATCH    : 2*CLK_DIV cycles with ip_latch high, then frame_done pulses
//
// All panel outputs come straight from flops. The panel sees true polarity;
// any board-level inversion happens outside this block.
module indicator_scan #(
    parameter int CLK_DIV  = 100,
    parameter int ROW_BITS = 36
) (
    input  logic                clk20,
    input  logic                reset,
    input  logic                clear,
    input  logic                lamp_test,
    input  logic [ROW_BITS-1:0] row0,
    input  logic [ROW_BITS-1:0] row1,
    input  logic [ROW_BITS-1:0] row2,
    input  logic [ROW_BITS-1:0] row3,
    indicator_scan_if.master    panel,
    output logic                frame_done
);

    localparam int FRAME_BITS = 4 * ROW_BITS;
    localparam int CNT_W      = $clog2(FRAME_BITS);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
    localparam logic [15:0]      DIV_LAST = 16'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_LATCH
    } state_t;

    state_t                  state_q,      state_d;
    logic [FRAME_BITS-1:0]   shadow_q,     shadow_d;
    logic [15:0]             div_cnt_q,    div_cnt_d;
    logic [CNT_W-1:0]        bit_cnt_q,    bit_cnt_d;
    logic                    latch_half_q, latch_half_d;
    logic                    ip_clk_q,     ip_clk_d;
    logic                    ip_out_q,     ip_out_d;
    logic                    ip_latch_q,   ip_latch_d;
    logic                    frame_done_q, frame_done_d;

    logic                    tick;
    logic [15:0]             div_cnt_next;

    // Half-bit-period tick at the divider's terminal count; the divider wraps on it.
    always_comb begin
        tick         = (div_cnt_q == DIV_LAST);
        div_cnt_next = tick ? 16'd0 : (div_cnt_q + 16'd1);
    end

    // Next-state and next-output logic for the scan sequencer; clear overrides everything.
    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        div_cnt_d    = div_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        latch_half_d = latch_half_q;
        ip_clk_d     = ip_clk_q;
        ip_out_d     = ip_out_q;
        ip_latch_d   = ip_latch_q;
        frame_done_d = 1'b0;

        case (state_q)
            ST_LOAD: begin
                // Coherent snapshot: rows are only ever looked at here.
                if (lamp_test) begin
                    shadow_d = '1;
                end else begin
                    shadow_d = {row0, row1, row2, row3};
                end
                ip_out_d     = lamp_test | row0[ROW_BITS-1];
                bit_cnt_d    = '0;
                div_cnt_d    = 16'd0;
                latch_half_d = 1'b0;
                ip_clk_d     = 1'b0;
                ip_latch_d   = 1'b0;
                state_d      = ST_SHIFT_LO;
            end

            ST_SHIFT_LO: begin
                div_cnt_d = div_cnt_next;
                ip_clk_d  = 1'b0;
                if (tick) begin
                    ip_clk_d = 1'b1;
                    state_d  = ST_SHIFT_HI;
                end
            end

            ST_SHIFT_HI: begin
                div_cnt_d = div_cnt_next;
                ip_clk_d  = 1'b1;
                if (tick) begin
                    // Falling edge of ip_clk: advance the data line.
                    ip_clk_d = 1'b0;
                    shadow_d = {shadow_q[FRAME_BITS-2:0], 1'b0};
                    ip_out_d = shadow_q[FRAME_BITS-2];
                    if (bit_cnt_q == LAST_BIT) begin
                        ip_latch_d   = 1'b1;
                        latch_half_d = 1'b0;
                        state_d      = ST_LATCH;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        state_d   = ST_SHIFT_LO;
                    end
                end
            end

            ST_LATCH: begin
                div_cnt_d  = div_cnt_next;
                ip_clk_d   = 1'b0;
                ip_latch_d = 1'b1;
                if (tick) begin
                    if (latch_half_q) begin
                        ip_latch_d   = 1'b0;
                        frame_done_d = 1'b1;
                        state_d      = ST_LOAD;
                    end else begin
                        latch_half_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_LOAD;
            end
        endcase

        // Frame restart: park in LOAD without snapshotting; the snapshot
        // happens on the first LOAD cycle after clear drops.
        if (clear) begin
            state_d      = ST_LOAD;
            shadow_d     = shadow_q;
            ip_out_d     = ip_out_q;
            div_cnt_d    = 16'd0;
            bit_cnt_d    = '0;
            latch_half_d = 1'b0;
            ip_clk_d     = 1'b0;
            ip_latch_d   = 1'b0;
            frame_done_d = 1'b0;
        end
    end

    // State and output registers with asynchronous reset into LOAD.
    always_ff @(posedge clk20 or posedge reset) begin
        if (reset) begin
            state_q      <= ST_LOAD;
            shadow_q     <= '0;
            div_cnt_q    <= 16'd0;
            bit_cnt_q    <= '0;
            latch_half_q <= 1'b0;
            ip_clk_q     <= 1'b0;
            ip_out_q     <= 1'b0;
            ip_latch_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            div_cnt_q    <= div_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            latch_half_q <= latch_half_d;
            ip_clk_q     <= ip_clk_d;
            ip_out_q     <= ip_out_d;
            ip_latch_q   <= ip_latch_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign panel.ip_clk   = ip_clk_q;
    assign panel.ip_out   = ip_out_q;
    assign panel.ip_latch = ip_latch_q;
    assign frame_done     = frame_done_q;

endmodule
